ptw_mem_arbiter: RTL and testbench

- Shares the single unified-memory read port between the IMEM and DMEM MMU page-table walkers.
- Replaces the ad-hoc IDLE/LFMI/LFMD/STALL sequencer with a proper arbiter:
  - req/response handshake
  - round-robin fairness
  - PTE address range and alignment checking
  - a busy output that the hazard unit uses to hold STALL_MMU
- Sits between the two MMU_unit instances and the unified RAM array, inside the memory subsystem.

---
 rtl/ptw_arb_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/ptw_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_arb_pkg.sv
// Shared definitions for the page-table-walker memory arbiter and the memory subsystem.
// Holds the FSM encoding, walker identifiers and the default RAM window.
package ptw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    localparam logic OWNER_IMEM = 1'b0;
    localparam logic OWNER_DMEM = 1'b1;

    localparam logic [31:0] DEF_RAM_BASE = 32'h8000_0000;
    localparam logic [31:0] DEF_RAM_SIZE = 32'd50000000;
    localparam int          DEF_IDX_W    = 24;

    // The lower-bound test is needed because addr - base wraps when addr < base.
    function automatic logic pte_addr_ok(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
        logic [31:0] offset;
        offset = addr - base;
        return (addr[1:0] == 2'b00) && (addr >= base) && (offset < size);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker; on a tie the requester that did not win last time is granted.
// req[0] is the IMEM walker, req[1] the DMEM walker.
module rr_arbiter2
    import ptw_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       next_last_grant
);

    always_comb begin
        grant           = 2'b00;
        next_last_grant = last_grant;
        if (advance) begin
            unique case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant == OWNER_DMEM) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
            if (grant != 2'b00) begin
                next_last_grant = grant[1] ? OWNER_DMEM : OWNER_IMEM;
            end
        end
    end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Arbitrates the unified RAM read port between the IMEM and DMEM page-table walkers,
// with address checking, one-cycle response pulses and a busy flag for the hazard unit.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | sample requests, pick winner, check PTE address
//   READ    | RAM read strobe and word index presented for one cycle
//   CAPTURE | RAM data valid, registered into owner's response data
//   DONE    | owner's response pulse; requests ignored
module ptw_mem_arbiter
    import ptw_arb_pkg::*;
#(
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
    parameter int          IDX_W    = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_resp_valid,
    output logic [31:0]      i_resp_data,
    output logic             i_resp_fault,

    input  logic             d_req,
    input  logic [31:0]      d_addr,
    output logic             d_resp_valid,
    output logic [31:0]      d_resp_data,
    output logic             d_resp_fault,

    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_word_idx,
    input  logic [31:0]      mem_rdata,

    output logic             busy,
    output logic             owner
);

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;

    logic [1:0]       grant;
    logic             arb_last_grant;
    logic             sel_owner;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_offset;
    logic             sel_ok;

    logic             rd_en_d;
    logic [IDX_W-1:0] idx_d;
    logic             i_valid_d, d_valid_d;
    logic             i_fault_d, d_fault_d;
    logic [31:0]      i_data_d, d_data_d;

    rr_arbiter2 u_rr (
        .req             ({d_req, i_req}),
        .last_grant      (last_grant_q),
        .advance         (state_q == ST_IDLE),
        .grant           (grant),
        .next_last_grant (arb_last_grant)
    );

    assign sel_owner  = grant[1] ? OWNER_DMEM : OWNER_IMEM;
    assign sel_addr   = grant[1] ? d_addr : i_addr;
    assign sel_offset = sel_addr - RAM_BASE;
    assign sel_ok     = pte_addr_ok(sel_addr, RAM_BASE, RAM_SIZE);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rd_en_d      = 1'b0;
        idx_d        = '0;
        i_valid_d    = 1'b0;
        d_valid_d    = 1'b0;
        i_fault_d    = 1'b0;
        d_fault_d    = 1'b0;
        i_data_d     = i_resp_data;
        d_data_d     = d_resp_data;

        unique case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    last_grant_d = arb_last_grant;
                    if (sel_ok) begin
                        state_d = ST_READ;
                        rd_en_d = 1'b1;
                        idx_d   = sel_offset[IDX_W+1:2];
                    end else begin
                        // Rejected requests skip the RAM entirely and answer next cycle.
                        state_d = ST_DONE;
                        if (sel_owner == OWNER_DMEM) begin
                            d_valid_d = 1'b1;
                            d_fault_d = 1'b1;
                            d_data_d  = '0;
                        end else begin
                            i_valid_d = 1'b1;
                            i_fault_d = 1'b1;
                            i_data_d  = '0;
                        end
                    end
                end
            end
            ST_READ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_DONE;
                if (last_grant_q == OWNER_DMEM) begin
                    d_valid_d = 1'b1;
                    d_data_d  = mem_rdata;
                end else begin
                    i_valid_d = 1'b1;
                    i_data_d  = mem_rdata;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= OWNER_DMEM;
            mem_rd_en    <= 1'b0;
            mem_word_idx <= '0;
            i_resp_valid <= 1'b0;
            i_resp_fault <= 1'b0;
            i_resp_data  <= '0;
            d_resp_valid <= 1'b0;
            d_resp_fault <= 1'b0;
            d_resp_data  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_rd_en    <= rd_en_d;
            mem_word_idx <= idx_d;
            i_resp_valid <= i_valid_d;
            i_resp_fault <= i_fault_d;
            i_resp_data  <= i_data_d;
            d_resp_valid <= d_valid_d;
            d_resp_fault <= d_fault_d;
            d_resp_data  <= d_data_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign owner = last_grant_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: transaction-level reference model of
// grant order, address legality, response latency and RAM contents.
module tb_ptw_mem_arbiter;

    localparam longint BASE = 64'h8000_0000;
    localparam longint SIZE = 64'd50000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr;
    logic        i_resp_valid, d_resp_valid;
    logic [31:0] i_resp_data, d_resp_data;
    logic        i_resp_fault, d_resp_fault;
    logic        mem_rd_en;
    logic [23:0] mem_word_idx;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, owner;

    int total = 0;
    int bad   = 0;

    int          m_last;
    logic [31:0] m_idata, m_ddata;

    ptw_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .i_resp_fault (i_resp_fault),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .d_resp_fault (d_resp_fault),
        .mem_rd_en    (mem_rd_en),
        .mem_word_idx (mem_word_idx),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .owner        (owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [23:0] idx);
        if (idx == 24'h000400) return 32'h2000_0C01;
        return {idx[7:0], idx} ^ 32'hA5C3_0F96;
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_word(mem_word_idx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One whole transaction, starting and ending in an IDLE cycle.
    task automatic do_txn(input bit ir, input logic [31:0] ia, input bit dr,
                          input logic [31:0] da, input bit keep,
                          input bit late_d, input logic [31:0] late_da);
        int          win;
        int          lat;
        logic [31:0] a;
        bit          flt;
        longint      off;
        logic [23:0] exp_idx;
        logic [31:0] exp_data;
        logic [1:0]  exp_flt;

        i_req = ir; i_addr = ia; d_req = dr; d_addr = da;
        if (ir && dr) win = (m_last == 1) ? 0 : 1;
        else          win = ir ? 0 : 1;
        m_last = win;
        a   = win ? da : ia;
        flt = (a % 4 != 0) || (longint'(a) < BASE) || (longint'(a) >= BASE + SIZE);
        off = longint'(a) - BASE;
        exp_idx  = 24'(off / 4);
        exp_data = flt ? 32'h0 : mem_word(exp_idx);
        lat = flt ? 1 : 3;

        for (int k = 1; k <= lat; k++) begin
            tick();
            if (k == 1 && !keep) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            total++;
            if (busy !== 1'b1) begin
                bad++; $display("FAIL busy k=%0d got=%b exp=1", k, busy);
            end
            total++;
            if (owner !== 1'(win)) begin
                bad++; $display("FAIL owner k=%0d got=%b exp=%0d", k, owner, win);
            end
            total++;
            if (mem_rd_en !== (k == 1 && !flt)) begin
                bad++; $display("FAIL mem_rd_en k=%0d addr=%h got=%b exp=%b", k, a, mem_rd_en, (k == 1 && !flt));
            end
            if (k == 1 && !flt) begin
                total++;
                if (mem_word_idx !== exp_idx) begin
                    bad++; $display("FAIL mem_word_idx addr=%h got=%h exp=%h", a, mem_word_idx, exp_idx);
                end
            end
            total++;
            if ({d_resp_valid, i_resp_valid} !== {(win == 1 && k == lat), (win == 0 && k == lat)}) begin
                bad++; $display("FAIL resp_valid k=%0d got d=%b i=%b win=%0d lat=%0d", k, d_resp_valid, i_resp_valid, win, lat);
            end
            if (k == lat) begin
                exp_flt = (win == 1) ? {flt, 1'b0} : {1'b0, flt};
                total++;
                if ({d_resp_fault, i_resp_fault} !== exp_flt) begin
                    bad++; $display("FAIL resp_fault addr=%h got d=%b i=%b exp=%b", a, d_resp_fault, i_resp_fault, exp_flt);
                end
                if (win == 1) m_ddata = exp_data; else m_idata = exp_data;
                total++;
                if (i_resp_data !== m_idata || d_resp_data !== m_ddata) begin
                    bad++; $display("FAIL resp_data addr=%h got i=%h d=%h exp i=%h d=%h", a, i_resp_data, d_resp_data, m_idata, m_ddata);
                end
            end
        end

        if (late_d) begin
            d_req = 1'b1; d_addr = late_da;
        end
        tick();
        total++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
            bad++; $display("FAIL after_done got busy=%b rd=%b iv=%b dv=%b exp all 0", busy, mem_rd_en, i_resp_valid, d_resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
        tick(); tick();
        rst = 1'b0;
        total++;
        if ({i_resp_valid, i_resp_fault, d_resp_valid, d_resp_fault, mem_rd_en, busy} !== 6'b0
            || i_resp_data !== 32'h0 || d_resp_data !== 32'h0 || mem_word_idx !== 24'h0) begin
            bad++; $display("FAIL reset_outputs got iv=%b if=%b dv=%b df=%b rd=%b busy=%b idata=%h ddata=%h idx=%h exp 0",
                            i_resp_valid, i_resp_fault, d_resp_valid, d_resp_fault, mem_rd_en, busy, i_resp_data, d_resp_data, mem_word_idx);
        end
        total++;
        if (owner !== 1'b1) begin
            bad++; $display("FAIL reset_owner got=%b exp=1", owner);
        end
        m_last = 1; m_idata = '0; m_ddata = '0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL idle_no_req busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_alternate();
        for (int n = 0; n < 6; n++) begin
            do_txn(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0004, 1'b1, 1'b0, 32'h0);
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_single_read();
        do_txn(1'b1, 32'h8000_1000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        total++;
        if (i_resp_data !== 32'h2000_0C01) begin
            bad++; $display("FAIL plan1_data got=%h exp=20000c01", i_resp_data);
        end
    endtask

    task automatic test_faults();
        do_txn(1'b0, 32'h0, 1'b1, 32'h8000_0002, 1'b0, 1'b0, 32'h0);
        do_txn(1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_txn(1'b1, 32'h82FA_F080, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_txn(1'b1, 32'h82FA_F07C, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_txn(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_drop_late();
        do_txn(1'b1, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0300);
        do_txn(1'b0, 32'h0, 1'b1, 32'h8000_0300, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_addr = 32'h8000_0040; d_req = 1'b0;
        tick(); tick();
        rst = 1'b1; i_req = 1'b0;
        tick();
        rst = 1'b0;
        total++;
        if (i_resp_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0 || owner !== 1'b1) begin
            bad++; $display("FAIL rst_capture got iv=%b busy=%b rd=%b owner=%b exp 0 0 0 1", i_resp_valid, busy, mem_rd_en, owner);
        end
        m_last = 1; m_idata = '0; m_ddata = '0;
        tick();
        total++;
        if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_no_pulse got iv=%b dv=%b exp 0", i_resp_valid, d_resp_valid);
        end
        do_txn(1'b1, 32'h8000_0010, 1'b1, 32'h8000_0020, 1'b0, 1'b0, 32'h0);

        d_req = 1'b1; d_addr = 32'h8000_0080;
        tick();
        rst = 1'b1; d_req = 1'b0;
        tick();
        rst = 1'b0;
        total++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b0 || d_resp_data !== 32'h0) begin
            bad++; $display("FAIL rst_read got rd=%b busy=%b ddata=%h exp 0 0 0", mem_rd_en, busy, d_resp_data);
        end
        m_last = 1; m_idata = '0; m_ddata = '0;
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000 + ($urandom_range(0, 12499999) * 4) + $urandom_range(1, 3);
            1:       return 32'h8000_0000 - ($urandom_range(1, 1000) * 4);
            2:       return 32'h82FA_F080 + ($urandom_range(0, 1000) * 4);
            default: return 32'h8000_0000 + ($urandom_range(0, 12499999) * 4);
        endcase
    endfunction

    task automatic test_random();
        bit ir, dr;
        for (int n = 0; n < 60; n++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) ir = 1'b1;
            do_txn(ir, rand_addr(), dr, rand_addr(), 1'b0, 1'b0, 32'h0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                total++;
                if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
                    bad++; $display("FAIL idle_gap got busy=%b rd=%b exp 0", busy, mem_rd_en);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single_read();
        test_faults();
        test_drop_late();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
